// File: rtl/pcie_lane_rx_pkg.sv
// Shared constants, symbol codes and FSM encoding for the single-lane PCIe symbol receiver.
package pcie_lane_rx_pkg;

  localparam int unsigned SYM_W    = 10;
  localparam int unsigned SKP_CW   = 16;

  localparam logic [SYM_W-1:0] COM_RDN = 10'h17C;
  localparam logic [SYM_W-1:0] COM_RDP = 10'h283;
  localparam logic [SYM_W-1:0] SKP_RDN = 10'h0BC;
  localparam logic [SYM_W-1:0] SKP_RDP = 10'h343;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CHECK,
    LOCKED
  } rx_state_e;

  function automatic logic is_com(input logic [SYM_W-1:0] s);
    return (s == COM_RDN) || (s == COM_RDP);
  endfunction

  function automatic logic is_skp(input logic [SYM_W-1:0] s);
    return (s == SKP_RDN) || (s == SKP_RDP);
  endfunction

endpackage

// File: rtl/pcie_lane_symbol_rx_if.sv
// Serial-in / aligned-symbol-out bundle of one receive lane.
// PCIE_RX_SKP_STRIP_EN adds the SKP_CNT stripped-SKP counter.
interface pcie_lane_symbol_rx_if;
  import pcie_lane_rx_pkg::*;

  logic             RX;
  logic             RX_;
  logic [SYM_W-1:0] SYM;
  logic             SYM_VALID;
  logic             SYM_IS_COM;
  logic             LOCKED;
  logic             ALIGN_ERR;
  logic             EIDLE;

`ifdef PCIE_RX_SKP_STRIP_EN
  logic [SKP_CW-1:0] SKP_CNT;

  modport master (output RX, RX_,
                  input  SYM, SYM_VALID, SYM_IS_COM, LOCKED, ALIGN_ERR, EIDLE, SKP_CNT);
  modport slave  (input  RX, RX_,
                  output SYM, SYM_VALID, SYM_IS_COM, LOCKED, ALIGN_ERR, EIDLE, SKP_CNT);
`else
  modport master (output RX, RX_,
                  input  SYM, SYM_VALID, SYM_IS_COM, LOCKED, ALIGN_ERR, EIDLE);
  modport slave  (input  RX, RX_,
                  output SYM, SYM_VALID, SYM_IS_COM, LOCKED, ALIGN_ERR, EIDLE);
`endif

endinterface

// File: rtl/pcie_lane_eidle_det.sv
// Data-bit qualifier and idle-run counter; eidle_hit marks the idle bit-time that
// completes an EIDLE_BITS-long run.
module pcie_lane_eidle_det #(
  parameter int unsigned EIDLE_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic rx_n,
  output logic bit_vld,
  output logic bit_val,
  output logic eidle_hit
);

  localparam int unsigned CNT_W = $clog2(EIDLE_BITS + 1);

  logic [CNT_W-1:0] idle_cnt;

  assign bit_vld   = rx ^ rx_n;
  assign bit_val   = rx;
  assign eidle_hit = !bit_vld && (idle_cnt >= CNT_W'(EIDLE_BITS - 1));

  // Saturating count of consecutive idle bit-times
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (bit_vld) begin
      idle_cnt <= '0;
    end else if (idle_cnt < CNT_W'(EIDLE_BITS)) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcie_lane_symbol_rx.sv
// Single-lane comma hunt, symbol lock and aligned 10-bit symbol delivery.
// PCIE_RX_SKP_STRIP_EN: drop SKP symbols while locked and count them on SKP_CNT.
module pcie_lane_symbol_rx
  import pcie_lane_rx_pkg::*;
#(
  parameter int unsigned LOCK_COMS       = 2,
  parameter int unsigned UNLOCK_MISALIGN = 4,
  parameter int unsigned EIDLE_BITS      = 16
) (
  input logic                 CLK_RX,
  input logic                 PERST,
  pcie_lane_symbol_rx_if.slave bus
);

  localparam int unsigned COM_W = $clog2(LOCK_COMS + 1);
  localparam int unsigned MIS_W = $clog2(UNLOCK_MISALIGN + 1);
  localparam logic [3:0]  LAST_BIT = 4'(SYM_W - 1);

  logic             bit_vld;
  logic             bit_val;
  logic             eidle_hit;

  rx_state_e        state;
  logic [SYM_W-1:0] sr;
  logic [3:0]       bit_cnt;
  logic             sr_new;
  logic [COM_W-1:0] com_cnt;
  logic [MIS_W-1:0] mis_cnt;
  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic             sym_is_com;
  logic             locked;
  logic             align_err;
  logic             eidle;
`ifdef PCIE_RX_SKP_STRIP_EN
  logic [SKP_CW-1:0] skp_cnt;
`endif

  // sr is evaluated one edge after its newest bit arrived; bit_cnt==0 then means a full symbol
  logic com_hit;
  logic at_bnd;
  assign com_hit = sr_new && is_com(sr);
  assign at_bnd  = sr_new && (bit_cnt == 4'd0);

  pcie_lane_eidle_det #(.EIDLE_BITS(EIDLE_BITS)) u_eidle_det (
    .clk       (CLK_RX),
    .rst       (PERST),
    .rx        (bus.RX),
    .rx_n      (bus.RX_),
    .bit_vld   (bit_vld),
    .bit_val   (bit_val),
    .eidle_hit (eidle_hit)
  );

  always_ff @(posedge CLK_RX or posedge PERST) begin
    if (PERST) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      sr_new     <= 1'b0;
      com_cnt    <= '0;
      mis_cnt    <= '0;
      sym        <= '0;
      sym_valid  <= 1'b0;
      sym_is_com <= 1'b0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
      eidle      <= 1'b1;
`ifdef PCIE_RX_SKP_STRIP_EN
      skp_cnt    <= '0;
`endif
    end else begin
      sym_valid  <= 1'b0;
      sym_is_com <= 1'b0;
      align_err  <= 1'b0;
      sr_new     <= bit_vld;
      if (bit_vld) begin
        sr      <= {bit_val, sr[SYM_W-1:1]};
        bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
      end

      // Electrical idle takes priority over anything found in sr this edge
      if (eidle_hit) begin
        state   <= IDLE;
        locked  <= 1'b0;
        eidle   <= 1'b1;
        com_cnt <= '0;
        mis_cnt <= '0;
`ifdef PCIE_RX_SKP_STRIP_EN
        skp_cnt <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (bit_vld) begin
              eidle <= 1'b0;
              state <= HUNT;
            end
          end

          HUNT: begin
            if (com_hit) begin
              // Re-frame: the bit arriving now (if any) is bit a of the next symbol
              bit_cnt <= bit_vld ? 4'd1 : 4'd0;
              com_cnt <= COM_W'(1);
              if (LOCK_COMS <= 1) begin
                state      <= LOCKED;
                locked     <= 1'b1;
                mis_cnt    <= '0;
                sym        <= sr;
                sym_valid  <= 1'b1;
                sym_is_com <= 1'b1;
              end else begin
                state <= CHECK;
              end
            end
          end

          CHECK: begin
            if (at_bnd) begin
              sym        <= sr;
              sym_valid  <= 1'b1;
              sym_is_com <= com_hit;
              if (com_hit) begin
                if (com_cnt >= COM_W'(LOCK_COMS - 1)) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  mis_cnt <= '0;
                end else begin
                  com_cnt <= com_cnt + COM_W'(1);
                end
              end
            end else if (com_hit) begin
              align_err <= 1'b1;
              com_cnt   <= '0;
              state     <= HUNT;
            end
          end

          LOCKED: begin
            if (at_bnd) begin
              if (com_hit) mis_cnt <= '0;
`ifdef PCIE_RX_SKP_STRIP_EN
              if (is_skp(sr)) begin
                if (skp_cnt != '1) skp_cnt <= skp_cnt + SKP_CW'(1);
              end else begin
                sym        <= sr;
                sym_valid  <= 1'b1;
                sym_is_com <= com_hit;
              end
`else
              sym        <= sr;
              sym_valid  <= 1'b1;
              sym_is_com <= com_hit;
`endif
            end else if (com_hit) begin
              align_err <= 1'b1;
              if (mis_cnt >= MIS_W'(UNLOCK_MISALIGN - 1)) begin
                state   <= HUNT;
                locked  <= 1'b0;
                mis_cnt <= '0;
                com_cnt <= '0;
`ifdef PCIE_RX_SKP_STRIP_EN
                skp_cnt <= '0;
`endif
              end else begin
                mis_cnt <= mis_cnt + MIS_W'(1);
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.SYM        = sym;
  assign bus.SYM_VALID  = sym_valid;
  assign bus.SYM_IS_COM = sym_is_com;
  assign bus.LOCKED     = locked;
  assign bus.ALIGN_ERR  = align_err;
  assign bus.EIDLE      = eidle;
`ifdef PCIE_RX_SKP_STRIP_EN
  assign bus.SKP_CNT    = skp_cnt;
`endif

endmodule
